// File: rtl/io_bus.sv
// io_bus: memory-mapped I/O window (LEDs, debounced keys, reload timer, IRQ) on the 6502 bus.
// Latency: read data registered, 1 clock; writes visible the clock after the write edge.
// Backpressure: none; the core bus never stalls, every cycle is accepted.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   ce, address, out, rd, we core bus cycle (enable, address, write data, strobes)
//   ext_in                  read data returned for addresses outside the window
//   in                      registered read data to the core
//   key                     raw asynchronous keys, active-low
//   led                     LED register
//   irq_n                   registered active-low interrupt request
module io_bus #(
    parameter logic [15:0] BASE     = 16'hC000,
    parameter int          DEBOUNCE = 16,
    parameter int          PRESCALE = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] address,
    input  logic [7:0]  out,
    input  logic        rd,
    input  logic        we,
    input  logic [7:0]  ext_in,
    output logic [7:0]  in,
    input  logic [3:0]  key,
    output logic [7:0]  led,
    output logic        irq_n
);

    localparam logic [3:0] REG_LED    = 4'd0;
    localparam logic [3:0] REG_KEY    = 4'd1;
    localparam logic [3:0] REG_KEDGE  = 4'd2;
    localparam logic [3:0] REG_TMR_LO = 4'd3;
    localparam logic [3:0] REG_TMR_HI = 4'd4;
    localparam logic [3:0] REG_CTRL   = 4'd5;
    localparam logic [3:0] REG_STATUS = 4'd6;

    localparam logic [DEBOUNCE-1:0] DB_MAX  = '1;
    localparam logic [PRESCALE-1:0] PRE_MAX = '1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [3:0] idx;
    logic       wr;
    logic       hi_wr;
    logic       snap_rd;

    assign hit     = (address[15:4] == BASE[15:4]);
    assign idx     = address[3:0];
    assign wr      = ce & we & hit;
    assign hi_wr   = wr & (idx == REG_TMR_HI);
    assign snap_rd = ce & rd & hit & (idx == REG_TMR_LO);

    // ------------------------------------------------------------------
    // Key synchronizer and debounce
    // ------------------------------------------------------------------
    logic [3:0]          key_s1;
    logic [3:0]          key_s2;
    logic [3:0]          stable;
    logic [DEBOUNCE-1:0] db_cnt [4];
    logic [3:0]          edge_set;
    logic [3:0]          kedge;
    logic                kf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // A key only changes state after the synchronized level has disagreed
    // with the accepted level for a full counter run; any agreeing sample
    // restarts the run, which is what filters bounce.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DEBOUNCE'(1);
                end
            end
        end
    end

    // Press event: the accepted level is about to fall from 1 to 0.
    always_comb begin
        edge_set = '0;
        for (int i = 0; i < 4; i++) begin
            edge_set[i] = stable[i] & ~key_s2[i] & (db_cnt[i] == DB_MAX);
        end
    end

    // Set beats a simultaneous write-one-to-clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kedge <= '0;
        end else begin
            kedge <= (kedge & ~((wr && idx == REG_KEDGE) ? out[3:0] : 4'h0)) | edge_set;
        end
    end

    assign kf = |kedge;

    // ------------------------------------------------------------------
    // Control, LED
    // ------------------------------------------------------------------
    logic [2:0] ctrl;   // {KIE, TIE, TEN}

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led  <= '0;
            ctrl <= '0;
        end else begin
            if (wr && idx == REG_LED) begin
                led <= out;
            end
            if (wr && idx == REG_CTRL) begin
                ctrl <= out[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic [PRESCALE-1:0] pre;
    logic                tick;
    logic [15:0]         reload;
    logic [15:0]         count;
    logic [7:0]          snap;
    logic                tf;
    logic                tf_set;

    assign tick   = ctrl[0] & (pre == PRE_MAX);
    // A TMR_HI write reloads the count, so an expiry in that same cycle is lost.
    assign tf_set = tick & (count == 16'd0) & ~hi_wr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (!ctrl[0] || hi_wr) begin
            pre <= '0;
        end else begin
            pre <= pre + PRESCALE'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reload <= '0;
            count  <= '0;
        end else begin
            if (wr && idx == REG_TMR_LO) begin
                reload[7:0] <= out;
            end
            if (hi_wr) begin
                reload[15:8] <= out;
                count        <= {out, reload[7:0]};
            end else if (tick) begin
                count <= (count == 16'd0) ? reload : count - 16'd1;
            end
        end
    end

    // Reading the low byte freezes the high byte so a 16-bit read is atomic
    // even if the counter decrements between the two bus cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
        end else if (snap_rd) begin
            snap <= count[15:8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tf <= 1'b0;
        end else begin
            tf <= (tf & ~(wr && idx == REG_STATUS && out[0])) | tf_set;
        end
    end

    // ------------------------------------------------------------------
    // Read data and interrupt
    // ------------------------------------------------------------------
    logic [7:0] rdata;

    always_comb begin
        rdata = 8'h00;
        case (idx)
            REG_LED:    rdata = led;
            REG_KEY:    rdata = {4'h0, ~stable};
            REG_KEDGE:  rdata = {4'h0, kedge};
            REG_TMR_LO: rdata = count[7:0];
            REG_TMR_HI: rdata = snap;
            REG_CTRL:   rdata = {5'h00, ctrl};
            REG_STATUS: rdata = {6'h00, kf, tf};
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in    <= '0;
            irq_n <= 1'b1;
        end else begin
            in    <= hit ? rdata : ext_in;
            irq_n <= ~((tf & ctrl[1]) | (kf & ctrl[2]));
        end
    end

endmodule

// File: tb/tb_io_bus.sv
// tb_io_bus: randomized bench for io_bus against a behavioural register-level model.
// Latency: model predicts in/led/irq_n one clock after each bus cycle.
// Backpressure: not applicable.
module tb_io_bus;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce, rd, we;
    logic [15:0] address;
    logic [7:0]  out, ext_in;
    logic [7:0]  in;
    logic [3:0]  key;
    logic [7:0]  led;
    logic        irq_n;

    int total = 0;
    int bad   = 0;

    io_bus #(.BASE(16'hC000), .DEBOUNCE(4), .PRESCALE(2)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .address(address), .out(out),
        .rd(rd), .we(we), .ext_in(ext_in), .in(in), .key(key), .led(led), .irq_n(irq_n)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model: register file semantics with integer timer/debounce
    // ------------------------------------------------------------------
    logic [7:0]  led_m, exp_in, snap_m;
    logic        irq_m, tf_m;
    logic [2:0]  ctrl_m;
    logic [15:0] reload_m, count_m;
    logic [3:0]  kedge_m, stable_m, s1_m, s2_m;
    int          run_m [4];
    int          pre_m;

    task automatic model_step();
        logic       hit_v, wr_v, hiwr_v, tick_v;
        logic [3:0] idx_v;
        logic [7:0] rv;
        if (!reset_n) begin
            led_m = 0; exp_in = 0; irq_m = 1; ctrl_m = 0; tf_m = 0; reload_m = 0;
            count_m = 0; snap_m = 0; kedge_m = 0; stable_m = 4'hF; s1_m = 4'hF; s2_m = 4'hF;
            pre_m = 0;
            for (int k = 0; k < 4; k++) run_m[k] = 0;
        end else begin
            hit_v  = (address[15:4] == 12'hC00);
            idx_v  = address[3:0];
            wr_v   = ce && we && hit_v;
            hiwr_v = wr_v && idx_v == 4'd4;
            case (idx_v)
                4'd0: rv = led_m;
                4'd1: rv = {4'h0, ~stable_m};
                4'd2: rv = {4'h0, kedge_m};
                4'd3: rv = count_m[7:0];
                4'd4: rv = snap_m;
                4'd5: rv = {5'h0, ctrl_m};
                4'd6: rv = {6'h0, kedge_m != 0, tf_m};
                default: rv = 8'h00;
            endcase
            exp_in = hit_v ? rv : ext_in;
            irq_m  = !((tf_m && ctrl_m[1]) || ((kedge_m != 0) && ctrl_m[2]));
            tick_v = ctrl_m[0] && (pre_m == 3);
            if (ce && rd && hit_v && idx_v == 4'd3) snap_m = count_m[15:8];
            if (wr_v && idx_v == 4'd6 && out[0]) tf_m = 0;
            if (tick_v && count_m == 16'd0 && !hiwr_v) tf_m = 1;
            if (hiwr_v) count_m = {out, reload_m[7:0]};
            else if (tick_v) count_m = (count_m == 16'd0) ? reload_m : count_m - 16'd1;
            if (hiwr_v || !ctrl_m[0]) pre_m = 0; else pre_m = (pre_m + 1) % 4;
            if (wr_v && idx_v == 4'd3) reload_m[7:0] = out;
            if (hiwr_v) reload_m[15:8] = out;
            if (wr_v && idx_v == 4'd0) led_m = out;
            if (wr_v && idx_v == 4'd5) ctrl_m = out[2:0];
            if (wr_v && idx_v == 4'd2) kedge_m = kedge_m & ~out[3:0];
            for (int k = 0; k < 4; k++) begin
                if (s2_m[k] == stable_m[k]) run_m[k] = 0;
                else begin
                    run_m[k]++;
                    if (run_m[k] == 16) begin
                        stable_m[k] = s2_m[k];
                        run_m[k] = 0;
                        if (!s2_m[k]) kedge_m[k] = 1;
                    end
                end
            end
            s2_m = s1_m;
            s1_m = key;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Bus driving
    // ------------------------------------------------------------------
    task automatic bus(input logic c, input logic r, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
        ce = c; rd = r; we = w; address = a; out = d;
        @(posedge clock);
        #1;
        ce = 0; rd = 0; we = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 0; ce = 0; rd = 0; we = 0; address = 0; out = 0; ext_in = 0; key = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        total++; if (in !== 8'h00) begin bad++; $display("FAIL reset_in: got %h want 00", in); end
        total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led: got %h want 00", led); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq: got %b want 1", irq_n); end
        reset_n = 1;
        idle(2);
    endtask

    task automatic test_led_decode();
        logic [7:0] d, e;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            if (i == 0) d = 8'h5A;
            bus(1, 0, 1, 16'hC000, d);
            total++; if (led !== led_m || led !== d) begin bad++; $display("FAIL led_write: got %h want %h", led, d); end
            bus(1, 1, 0, 16'hC000, 8'h00);
            total++; if (in !== exp_in || in !== d) begin bad++; $display("FAIL led_read: got %h want %h", in, d); end
            e = 8'($urandom);
            if (i == 0) e = 8'h3C;
            ext_in = e;
            bus(1, 1, 0, 16'hC010, 8'h00);
            total++; if (in !== e) begin bad++; $display("FAIL miss_read: got %h want %h", in, e); end
            bus(1, 0, 1, 16'hC0F0, ~d);
            total++; if (led !== led_m || led !== d) begin bad++; $display("FAIL miss_write: got %h want %h", led, d); end
        end
        for (int r = 7; r < 16; r++) begin
            bus(1, 0, 1, 16'hC000 | 16'(r), 8'($urandom));
            bus(1, 1, 0, 16'hC000 | 16'(r), 8'h00);
            total++; if (in !== 8'h00) begin bad++; $display("FAIL unused_reg%0d: got %h want 00", r, in); end
        end
    endtask

    task automatic test_timer();
        int   first;
        logic found;
        bus(1, 0, 1, 16'hC003, 8'h03);
        bus(1, 0, 1, 16'hC004, 8'h00);
        bus(1, 0, 1, 16'hC005, 8'h03);
        first = -1;
        for (int c = 1; c <= 18; c++) begin
            idle(1);
            total++; if (irq_n !== irq_m) begin bad++; $display("FAIL timer_irq_c%0d: got %b want %b", c, irq_n, irq_m); end
            if (irq_n === 1'b0 && first < 0) first = c;
        end
        total++; if (first != 17) begin bad++; $display("FAIL timer_irq_latency: got %0d want 17", first); end
        bus(1, 1, 0, 16'hC006, 8'h00);
        total++; if (in !== exp_in || in[0] !== 1'b1) begin bad++; $display("FAIL timer_tf_read: got %h want %h", in, exp_in); end
        bus(1, 0, 1, 16'hC006, 8'h01);
        idle(1);
        total++; if (irq_n !== irq_m || irq_n !== 1'b1) begin bad++; $display("FAIL timer_w1c_irq: got %b want 1", irq_n); end
        // W1C landing on the expiry edge: the set must win
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (ctrl_m[0] && pre_m == 3 && count_m == 16'd0) found = 1;
            else idle(1);
        end
        total++; if (!found) begin bad++; $display("FAIL timer_expiry_search: got none want expiry within 64"); end
        bus(1, 0, 1, 16'hC006, 8'h01);
        bus(1, 1, 0, 16'hC006, 8'h00);
        total++; if (in !== exp_in || in[0] !== 1'b1) begin bad++; $display("FAIL timer_collision_tf: got %h want %h", in, exp_in); end
        idle(1);
        total++; if (irq_n !== irq_m) begin bad++; $display("FAIL timer_collision_irq: got %b want %b", irq_n, irq_m); end
        bus(1, 0, 1, 16'hC005, 8'h00);
        bus(1, 0, 1, 16'hC006, 8'h01);
    endtask

    task automatic test_atomic_read();
        logic [7:0] lo, hi;
        bus(1, 0, 1, 16'hC005, 8'h01);
        bus(1, 0, 1, 16'hC003, 8'h00);
        bus(1, 0, 1, 16'hC004, 8'h01);
        idle(3);
        bus(1, 1, 0, 16'hC003, 8'h00);
        total++; if (in !== exp_in || in !== 8'h00) begin bad++; $display("FAIL atomic_lo: got %h want 00", in); end
        bus(1, 1, 0, 16'hC004, 8'h00);
        total++; if (in !== exp_in || in !== 8'h01) begin bad++; $display("FAIL atomic_hi: got %h want 01", in); end
        for (int i = 0; i < 4; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            bus(1, 0, 1, 16'hC003, lo);
            bus(1, 0, 1, 16'hC004, hi);
            idle($urandom_range(0, 6));
            bus(1, 1, 0, 16'hC003, 8'h00);
            total++; if (in !== exp_in) begin bad++; $display("FAIL atomic_rand_lo%0d: got %h want %h", i, in, exp_in); end
            bus(1, 1, 0, 16'hC004, 8'h00);
            total++; if (in !== exp_in) begin bad++; $display("FAIL atomic_rand_hi%0d: got %h want %h", i, in, exp_in); end
        end
        bus(1, 0, 1, 16'hC005, 8'h00);
    endtask

    task automatic test_ce_gating();
        logic [7:0] l;
        l = led_m;
        bus(0, 0, 1, 16'hC000, ~l);
        total++; if (led !== l) begin bad++; $display("FAIL ce_led: got %h want %h", led, l); end
        bus(1, 0, 1, 16'hC003, 8'h00);
        bus(1, 0, 1, 16'hC004, 8'h5A);
        bus(0, 1, 0, 16'hC003, 8'h00);
        bus(1, 1, 0, 16'hC004, 8'h00);
        total++; if (in !== exp_in || in === 8'h5A) begin bad++; $display("FAIL ce_snap: got %h want %h", in, exp_in); end
        bus(1, 1, 0, 16'hC003, 8'h00);
        bus(1, 1, 0, 16'hC004, 8'h00);
        total++; if (in !== 8'h5A) begin bad++; $display("FAIL ce_snap_on: got %h want 5a", in); end
    endtask

    task automatic test_debounce();
        bus(1, 0, 1, 16'hC006, 8'h01);
        bus(1, 0, 1, 16'hC005, 8'h04);
        for (int i = 0; i < 40; i++) begin
            key = ((i / 5) % 2 == 0) ? 4'b1101 : 4'b1111;
            idle(1);
        end
        bus(1, 1, 0, 16'hC001, 8'h00);
        total++; if (in !== exp_in || in !== 8'h00) begin bad++; $display("FAIL bounce_key: got %h want 00", in); end
        bus(1, 1, 0, 16'hC002, 8'h00);
        total++; if (in !== exp_in || in !== 8'h00) begin bad++; $display("FAIL bounce_edge: got %h want 00", in); end
        key = 4'b1101;
        idle(20);
        total++; if (irq_n !== irq_m || irq_n !== 1'b0) begin bad++; $display("FAIL press_irq: got %b want 0", irq_n); end
        bus(1, 1, 0, 16'hC001, 8'h00);
        total++; if (in !== exp_in || in !== 8'h02) begin bad++; $display("FAIL press_key: got %h want 02", in); end
        bus(1, 1, 0, 16'hC002, 8'h00);
        total++; if (in !== exp_in || in !== 8'h02) begin bad++; $display("FAIL press_edge: got %h want 02", in); end
        bus(1, 0, 1, 16'hC002, 8'h02);
        idle(1);
        total++; if (irq_n !== irq_m || irq_n !== 1'b1) begin bad++; $display("FAIL edge_clear_irq: got %b want 1", irq_n); end
        bus(1, 1, 0, 16'hC002, 8'h00);
        total++; if (in !== 8'h00) begin bad++; $display("FAIL edge_cleared: got %h want 00", in); end
        key = 4'hF;
        idle(20);
        bus(1, 1, 0, 16'hC002, 8'h00);
        total++; if (in !== exp_in || in !== 8'h00) begin bad++; $display("FAIL release_edge: got %h want 00", in); end
        bus(1, 1, 0, 16'hC001, 8'h00);
        total++; if (in !== exp_in || in !== 8'h00) begin bad++; $display("FAIL release_key: got %h want 00", in); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
            ext_in = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a = 16'hC000 | 16'($urandom_range(0, 15));
            else a = 16'($urandom);
            bus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), a, 8'($urandom));
            total++; if (in !== exp_in) begin bad++; $display("FAIL rand_in%0d: got %h want %h", i, in, exp_in); end
            total++; if (led !== led_m) begin bad++; $display("FAIL rand_led%0d: got %h want %h", i, led, led_m); end
            total++; if (irq_n !== irq_m) begin bad++; $display("FAIL rand_irq%0d: got %b want %b", i, irq_n, irq_m); end
        end
        key = 4'hF;
    endtask

    task automatic test_reset_midrun();
        bus(1, 0, 1, 16'hC000, 8'hA5);
        bus(1, 0, 1, 16'hC003, 8'hFF);
        bus(1, 0, 1, 16'hC004, 8'hFF);
        bus(1, 0, 1, 16'hC005, 8'h03);
        idle(5);
        reset_n = 0;
        #2;
        total++; if (led !== 8'h00) begin bad++; $display("FAIL midreset_led: got %h want 00", led); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL midreset_irq: got %b want 1", irq_n); end
        total++; if (dut.count !== 16'h0000) begin bad++; $display("FAIL midreset_count: got %h want 0000", dut.count); end
        #2;
        reset_n = 1;
        bus(1, 1, 0, 16'hC005, 8'h00);
        total++; if (in !== 8'h00) begin bad++; $display("FAIL midreset_ctrl: got %h want 00", in); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_led_decode();
        test_timer();
        test_atomic_read();
        test_ce_gating();
        test_debounce();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
